// File: rtl/dlx_global_pkg.sv
// Shared DLX types and constants for the fetch front end.
package dlx_global_pkg;

   localparam int unsigned DLX_WORD_W = 32;
   localparam int unsigned DLX_ADDR_W = 32;

   typedef logic [DLX_WORD_W-1:0] dlx_word;
   typedef logic [DLX_ADDR_W-1:0] dlx_addr;

   // Canonical bubble instruction loaded into IF/ID when it holds nothing real.
   localparam dlx_word DLX_NOP = 32'h5400_0000;

   // Prefetch queue payload: instruction and the address that follows it.
   typedef struct packed {
      dlx_word ir;
      dlx_addr npc;
   } if_entry_t;

   // Force an address onto a word boundary.
   function automatic dlx_addr dlx_align_word(input dlx_addr a);
      return {a[DLX_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/dlx_if_fifo.sv
// Generic synchronous FIFO; flush wins over push and pop, no empty bypass.
module dlx_if_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Status and qualified handshakes; a push into a full queue needs a same-cycle pop.
   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rd_ptr];
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dlx_pipe_if_pf.sv
// DLX instruction fetch with prefetch queue, credit-based I-cache issue and branch squash.
module dlx_pipe_if_pf
   import dlx_global_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          PF_DEPTH  = 4,
   parameter int unsigned          MAX_OUTST = 2,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter int unsigned          PC_INC    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              dc_wait,
   input  logic              id_cond,
   input  logic [ADDR_W-1:0] id_npc,
   output logic              ic_req,
   output logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_ready,
   input  logic              ic_rvalid,
   input  logic [DATA_W-1:0] ic_rdata,
   output logic              if_id_valid,
   output logic [DATA_W-1:0] if_id_ir,
   output logic [ADDR_W-1:0] if_id_npc,
   output logic              if_misalign
);

   localparam int unsigned ENT_W    = DATA_W + ADDR_W;
   localparam int unsigned PF_CNT_W = $clog2(PF_DEPTH+1);
   localparam int unsigned OS_W     = $clog2(MAX_OUTST+1);
   localparam int unsigned SUM_W    = $clog2(PF_DEPTH+MAX_OUTST+1);

   logic [ADDR_W-1:0]   pc;
   logic [OS_W-1:0]     outst;
   logic [OS_W-1:0]     drop;
   logic                advance;
   logic                redirect;
   logic                credit_ok;
   logic                issue;
   logic                pf_push;
   logic                pf_pop;
   logic [ENT_W-1:0]    pf_din;
   logic [ENT_W-1:0]    pf_dout;
   logic                pf_full;
   logic                pf_empty;
   logic [PF_CNT_W-1:0] pf_count;
   logic [ADDR_W-1:0]   aq_dout;
   logic                aq_full;
   logic                aq_empty;

   // Issue gating and response routing; in-flight requests reserve queue slots.
   always_comb begin
      advance   = !stall && !dc_wait;
      redirect  = id_cond && advance;
      credit_ok = (SUM_W'(pf_count) + SUM_W'(outst)) < SUM_W'(PF_DEPTH);
      ic_req    = rst_n && credit_ok && !aq_full && !redirect;
      ic_addr   = pc;
      issue     = ic_req && ic_ready;
      pf_push   = ic_rvalid && (drop == '0);
      pf_pop    = advance && !redirect;
      pf_din    = {ic_rdata, aq_dout + ADDR_W'(PC_INC)};
   end

   // Prefetch queue of {ir, npc} entries.
   dlx_if_fifo #(.WIDTH(ENT_W), .DEPTH(PF_DEPTH)) u_pf_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pf_push),
      .pop   (pf_pop),
      .flush (redirect),
      .din   (pf_din),
      .dout  (pf_dout),
      .full  (pf_full),
      .empty (pf_empty),
      .count (pf_count)
   );

   // Fetch addresses of in-flight requests; its occupancy is the outstanding count.
   dlx_if_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_addr_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (ic_rvalid),
      .flush (1'b0),
      .din   (pc),
      .dout  (aq_dout),
      .full  (aq_full),
      .empty (aq_empty),
      .count (outst)
   );

   // Fetch PC: redirect to aligned target, else step on each accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pc <= RESET_PC;
      else if (redirect) pc <= {id_npc[ADDR_W-1:2], 2'b00};
      else if (issue)    pc <= pc + ADDR_W'(PC_INC);
   end

   // Wrong-path response counter; a response landing on the redirect cycle is already gone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         drop <= '0;
      else if (redirect)                  drop <= outst - OS_W'(ic_rvalid);
      else if (ic_rvalid && drop != '0)   drop <= drop - OS_W'(1);
   end

   // IF/ID pipeline register and misalignment pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_valid <= 1'b0;
         if_id_ir    <= DATA_W'(DLX_NOP);
         if_id_npc   <= '0;
         if_misalign <= 1'b0;
      end else begin
         if_misalign <= redirect && (id_npc[1:0] != 2'b00);
         if (advance) begin
            if (redirect || pf_empty) begin
               if_id_valid <= 1'b0;
               if_id_ir    <= DATA_W'(DLX_NOP);
            end else begin
               if_id_valid <= 1'b1;
               if_id_ir    <= pf_dout[ENT_W-1 -: DATA_W];
               if_id_npc   <= pf_dout[ADDR_W-1:0];
            end
         end
      end
   end

   // Responses only for requests actually in flight.
   a_rvalid_outst: assert property (@(posedge clk) disable iff (!rst_n)
      !(ic_rvalid && aq_empty));

   // Credit scheme keeps the prefetch queue from overflowing.
   a_pf_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(pf_push && pf_full && !pf_pop && !redirect));

endmodule
